// File: rtl/de270_irq_pkg.sv
// Shared constants for the de270 interrupt aggregator: register map and VECTOR layout.
package de270_irq_pkg;

  localparam int unsigned MAX_SRC       = 16;
  localparam int unsigned VEC_VALID_BIT = 15;
  localparam int unsigned VEC_IDX_W     = 4;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  function automatic logic [15:0] vec_word(input logic valid, input logic [VEC_IDX_W-1:0] idx);
    logic [15:0] w;
    w = '0;
    w[VEC_VALID_BIT] = valid;
    w[VEC_IDX_W-1:0] = idx;
    return w;
  endfunction

endpackage

// File: rtl/de270_irq_aggregator_prio_enc.sv
// Lowest-index-wins priority encoder feeding the VECTOR register.
module de270_irq_prio_enc
  import de270_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   req_i,
  output logic                 valid_o,
  output logic [VEC_IDX_W-1:0] idx_o
);

  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_i[i] && !found) begin
        found = 1'b1;
        idx_o = VEC_IDX_W'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/de270_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source edge/level latching, mask, combined irq, priority VECTOR.
// Define DE270_IRQ_SYNC_EN to insert a 2-flop synchronizer ahead of the source sampling stage.
module de270_irq_aggregator
  import de270_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] s_q, sdly_q, sdly_d;
  logic [NUM_SRC-1:0] edge_q, edge_d, mask_q, mask_d, mode_q, mode_d;
  logic [1:0]         warm_q, warm_d;
  logic               primed;
  logic [15:0]        readdata_d;
  logic               irq_d;

`ifdef DE270_IRQ_SYNC_EN
  localparam logic [1:0] WARM_CYC = 2'd3;
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  localparam logic [1:0] WARM_CYC = 2'd1;
  assign src = irq_in;
`endif

  // Until the first post-reset sample has reached s, the delayed copy tracks the
  // same value so a source already high at reset release never looks like a rise.
  assign primed = (warm_q == WARM_CYC);
  assign warm_d = primed ? warm_q : warm_q + 2'd1;
  assign sdly_d = primed ? s_q : src;

  logic                 wr_en;
  logic [NUM_SRC-1:0]   wdata, rise, set_b, clr_b, pend_eff, active;
  logic                 vec_valid;
  logic [VEC_IDX_W-1:0] vec_idx;
  logic                 unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en = chipselect && !write_n;
  assign wdata = writedata[NUM_SRC-1:0];
  assign rise  = s_q & ~sdly_q;

  // Set and clear only touch edge-mode bits; set wins over a same-cycle clear.
  assign set_b  = (rise | ((wr_en && address == ADDR_SWSET) ? wdata : '0)) & mode_q;
  assign clr_b  = ((wr_en && address == ADDR_PENDING) ? wdata : '0) & mode_q;
  assign edge_d = (edge_q & ~clr_b) | set_b;
  assign mask_d = (wr_en && address == ADDR_MASK) ? wdata : mask_q;
  assign mode_d = (wr_en && address == ADDR_MODE) ? wdata : mode_q;

  assign pend_eff = (mode_q & edge_q) | (~mode_q & s_q);
  assign active   = pend_eff & mask_q;
  assign irq_d    = |active;

  de270_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req_i   (active),
    .valid_o (vec_valid),
    .idx_o   (vec_idx)
  );

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING: readdata_d = 16'(pend_eff);
      ADDR_MASK:    readdata_d = 16'(mask_q);
      ADDR_MODE:    readdata_d = 16'(mode_q);
      ADDR_VECTOR:  readdata_d = vec_word(vec_valid, vec_idx);
      ADDR_RAW:     readdata_d = 16'(s_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q      <= '0;
      sdly_q   <= '0;
      warm_q   <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      s_q      <= src;
      sdly_q   <= sdly_d;
      warm_q   <= warm_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      readdata <= readdata_d;
      irq      <= irq_d;
    end
  end

endmodule

// File: tb/tb_de270_irq_aggregator.sv
// Self-checking bench for de270_irq_aggregator: directed tables, timing sequences and a random run vs a reference model.
module tb_de270_irq_aggregator;

  localparam int NS = 8;
  localparam logic [15:0] NSM = 16'h00FF;
`ifdef DE270_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int D = LAT - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [NS-1:0] irq_in = '0;
  logic        irq;

  int total = 0;
  int bad = 0;

  de270_irq_aggregator #(.NUM_SRC(NS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: keeps the full post-reset history of irq_in and derives
  // the sampled level and rises from it directly.
  logic [15:0] hist[$];
  logic [15:0] m_mask, m_mode, m_edge, m_rd;
  logic        m_irq;

  function automatic logic [15:0] samp(int k);
    if (k < 0) return 16'h0;
    return hist[k];
  endfunction

  task automatic model_clear();
    hist.delete();
    m_mask = '0; m_mode = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    int t;
    logic [15:0] s_now, s_prev, rise, pend, act, vec, wd, setv, clrv;
    hist.push_back(16'(irq_in));
    t = hist.size() - 1;
    s_now  = samp(t - LAT);
    s_prev = samp(t - LAT - 1);
    rise   = (t - LAT - 1 >= 0) ? (s_now & ~s_prev) : 16'h0;
    pend   = ((m_mode & m_edge) | (~m_mode & s_now)) & NSM;
    act    = pend & m_mask;
    vec    = 16'h0;
    for (int i = NS - 1; i >= 0; i--)
      if (act[i]) vec = 16'h8000 | 16'(i);
    case (address)
      3'd0: m_rd = pend;
      3'd1: m_rd = m_mask;
      3'd2: m_rd = m_mode;
      3'd3: m_rd = vec;
      3'd4: m_rd = s_now;
      default: m_rd = 16'h0;
    endcase
    m_irq = (act != 16'h0);
    wd   = writedata & NSM;
    setv = rise;
    clrv = 16'h0;
    if (chipselect && !write_n) begin
      if (address == 3'd5) setv = setv | wd;
      if (address == 3'd0) clrv = wd;
    end
    m_edge = ((m_edge & ~(clrv & m_mode)) | (setv & m_mode)) & NSM;
    if (chipselect && !write_n && address == 3'd1) m_mask = wd;
    if (chipselect && !write_n && address == 3'd2) m_mode = wd;
  endtask

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("irq", 16'(irq), 16'(m_irq));
    check("rdata", readdata, m_rd);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #1;
    check("rst_rdata", readdata, 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic wr(logic [2:0] a, logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(string nm, logic [2:0] a, logic [15:0] exp);
    address = a;
    tick();
    check(nm, readdata, exp);
  endtask

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } op_t;

  op_t reset_tbl[8];
  op_t vec_tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) reset_tbl[i] = '{1'b0, 3'(i), 16'h0, 16'h0};
    vec_tbl[0] = '{1'b0, 3'd3, 16'h0,    16'h8003};
    vec_tbl[1] = '{1'b1, 3'd0, 16'h0008, 16'h0};
    vec_tbl[2] = '{1'b0, 3'd3, 16'h0,    16'h8005};
    vec_tbl[3] = '{1'b1, 3'd0, 16'h0020, 16'h0};
    vec_tbl[4] = '{1'b0, 3'd3, 16'h0,    16'h0000};

    model_clear();
    // reset: every register reads 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("reset_rd%0d", i), reset_tbl[i].a, reset_tbl[i].exp);
      check("reset_irq", 16'(irq), 16'h0);
    end

    // source 0 high across reset release: no edge
    irq_in = 8'h01;
    do_reset();
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    repeat (6) tick();
    rd("rsthigh_pend", 3'd0, 16'h0000);
    check("rsthigh_irq", 16'(irq), 16'h0);
    rd("rsthigh_raw", 3'd4, 16'h0001);

    // edge pulse on source 0
    irq_in = '0;
    do_reset();
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    repeat (3) tick();
    address = 3'd0;
    irq_in = 8'h01;
    tick();
    irq_in = '0;
    for (int c = 2; c <= 3 + D; c++) begin
      tick();
      if (c == 2 + D) check("edge_pre", 16'(irq), 16'h0);
      if (c == 3 + D) check("edge_irq", 16'(irq), 16'h1);
    end
    rd("edge_pend", 3'd0, 16'h0001);
    wr(3'd0, 16'h0001);
    check("clr_w1", 16'(irq), 16'h1);
    tick();
    check("clr_w2", 16'(irq), 16'h0);

    // level hold on source 2 with an ineffective PENDING clear
    do_reset();
    wr(3'd1, 16'h0004);
    repeat (3) tick();
    for (int k = 0; k < 15; k++) begin
      irq_in = (k < 10) ? 8'h04 : 8'h00;
      if (k == 5) begin
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0004;
      end else begin
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      end
      tick();
      check($sformatf("level_c%0d", k + 1), 16'(irq),
            16'((k + 1 >= 2 + D) && (k + 1 <= 11 + D)));
    end

    // priority vector
    do_reset();
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00FF);
    repeat (3) tick();
    irq_in = 8'h28;
    tick();
    irq_in = '0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      if (vec_tbl[i].is_wr) wr(vec_tbl[i].a, vec_tbl[i].d);
      else rd($sformatf("vec%0d", i), vec_tbl[i].a, vec_tbl[i].exp);
    end
    tick();
    check("vec_irq_low", 16'(irq), 16'h0);

    // set beats same-cycle clear; software trigger
    do_reset();
    wr(3'd2, 16'h0012);
    repeat (3) tick();
    wr(3'd5, 16'h0002);
    rd("sw_bit1", 3'd0, 16'h0002);
    irq_in = 8'h02;
    tick();
    repeat (D) tick();
    wr(3'd0, 16'h0002);
    rd("setwins", 3'd0, 16'h0002);
    wr(3'd5, 16'h0010);
    rd("swset4", 3'd0, 16'h0012);
    rd("swset_rd0", 3'd5, 16'h0000);

    // random traffic against the model, with one mid-run reset
    irq_in = '0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      irq_in = irq_in ^ 8'($urandom & $urandom & $urandom);
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = 16'($urandom);
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = 16'($urandom);
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
